// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg
//   Shared definitions for the spiking-network inference sequencer:
//   default widths, the WAIT timeout, the result-class width and the
//   sequencer state encoding.
package snn_ctrl_pkg;

   localparam int N_IN_DEF    = 8;
   localparam int N_OUT_DEF   = 8;
   localparam int CNT_W_DEF   = 5;
   localparam int STEP_W_DEF  = 5;
   localparam int TIMEOUT_DEF = 8;
   localparam int CLASS_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_FIRE  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DCLK  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/spike_count_argmax.sv
// spike_count_argmax
//   Per-neuron saturating spike counters plus a registered argmax.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     clr_i        clear all counters (and the class) at the next edge
//     acc_i        add one to every counter whose spikes_i bit is set
//     spikes_i     output spike vector from the network
//     counts_o     packed counters, neuron i at [i*CNT_W +: CNT_W]
//     class_o      index of the largest counter, ties to the lowest index
module spike_count_argmax
   import snn_ctrl_pkg::*;
#(
   parameter int N_OUT = N_OUT_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int CLS_W = CLASS_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr_i,
   input  logic                   acc_i,
   input  logic [N_OUT-1:0]       spikes_i,
   output logic [N_OUT*CNT_W-1:0] counts_o,
   output logic [CLS_W-1:0]       class_o
);

   logic [N_OUT*CNT_W-1:0] counts_q, counts_d;
   logic [CLS_W-1:0]       class_q, class_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   // Strict '>' keeps the earliest index on ties; all-zero gives 0.
   function automatic logic [CLS_W-1:0] argmax(input logic [N_OUT*CNT_W-1:0] v);
      logic [CNT_W-1:0] best;
      logic [CLS_W-1:0] idx;
      best = v[CNT_W-1:0];
      idx  = '0;
      for (int i = 1; i < N_OUT; i++) begin
         if (v[i*CNT_W +: CNT_W] > best) begin
            best = v[i*CNT_W +: CNT_W];
            idx  = CLS_W'(i);
         end
      end
      return idx;
   endfunction

   always_comb begin
      counts_d = counts_q;
      if (clr_i) begin
         counts_d = '0;
      end else if (acc_i) begin
         for (int i = 0; i < N_OUT; i++) begin
            if (spikes_i[i]) counts_d[i*CNT_W +: CNT_W] = sat_inc(counts_q[i*CNT_W +: CNT_W]);
         end
      end
      // Class is derived from the next counts so it is never a cycle stale.
      class_d = argmax(counts_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counts_q <= '0;
         class_q  <= '0;
      end else begin
         counts_q <= counts_d;
         class_q  <= class_d;
      end
   end

   assign counts_o = counts_q;
   assign class_o  = class_q;

endmodule

// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer
//   Runs one inference of num_steps timesteps on the delayed spiking
//   network: per step it takes an input frame (valid/ready), pulses
//   net_enable, waits for net_data_ready, accumulates output spikes and
//   pulses net_delay_clk; it then offers counts and argmax class over a
//   valid/ready result handshake.
//   Ports:
//     clk, reset                         clock, asynchronous active-high reset
//     start, num_steps                   inference request (sampled in IDLE)
//     in_valid/in_ready/in_spikes        input frame handshake
//     net_input_spikes                   registered frame to the network
//     net_enable, net_delay_clk          one-cycle pulses per timestep
//     net_output_spikes, net_data_ready  network result
//     busy                               not IDLE
//     res_valid/res_ready                result handshake
//     res_class, res_counts              argmax class and per-neuron counts
//     err_timeout                        sticky WAIT-timeout flag
module snn_inference_sequencer
   import snn_ctrl_pkg::*;
#(
   parameter int N_IN    = N_IN_DEF,
   parameter int N_OUT   = N_OUT_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int STEP_W  = STEP_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [STEP_W-1:0]      num_steps,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN-1:0]        in_spikes,
   output logic [N_IN-1:0]        net_input_spikes,
   output logic                   net_enable,
   output logic                   net_delay_clk,
   input  logic [N_OUT-1:0]       net_output_spikes,
   input  logic                   net_data_ready,
   output logic                   busy,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [CLASS_W-1:0]     res_class,
   output logic [N_OUT*CNT_W-1:0] res_counts,
   output logic                   err_timeout
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   state_t            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [STEP_W-1:0] nsteps_q, nsteps_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              err_q, err_d;
   logic [N_IN-1:0]   frame_q, frame_d;
   logic              cnt_clr, cnt_acc;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      nsteps_d = nsteps_q;
      timer_d  = timer_q;
      err_d    = err_q;
      frame_d  = frame_q;
      cnt_clr  = 1'b0;
      cnt_acc  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clr = 1'b1;
               err_d   = 1'b0;
               step_d  = '0;
               if (num_steps != '0) begin
                  nsteps_d = num_steps;
                  state_d  = ST_FETCH;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end
         ST_FETCH: begin
            if (in_valid) begin
               frame_d = in_spikes;
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            // A response on the last permitted cycle still wins over the timeout.
            if (net_data_ready) begin
               cnt_acc = 1'b1;
               state_d = ST_DCLK;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DCLK: begin
            if (step_q == nsteps_q - STEP_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               step_d  = step_q + STEP_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         nsteps_q <= '0;
         timer_q  <= '0;
         err_q    <= 1'b0;
         frame_q  <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         nsteps_q <= nsteps_d;
         timer_q  <= timer_d;
         err_q    <= err_d;
         frame_q  <= frame_d;
      end
   end

   spike_count_argmax #(
      .N_OUT (N_OUT),
      .CNT_W (CNT_W),
      .CLS_W (CLASS_W)
   ) u_count (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (cnt_clr),
      .acc_i    (cnt_acc),
      .spikes_i (net_output_spikes),
      .counts_o (res_counts),
      .class_o  (res_class)
   );

   // Pure decodes of the state register: no input reaches these outputs.
   assign in_ready         = (state_q == ST_FETCH);
   assign net_enable       = (state_q == ST_FIRE);
   assign net_delay_clk    = (state_q == ST_DCLK);
   assign res_valid        = (state_q == ST_DONE);
   assign busy             = (state_q != ST_IDLE);
   assign err_timeout      = err_q;
   assign net_input_spikes = frame_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
module tb_snn_inference_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  num_steps = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_spikes = '0;
   logic [7:0]  net_input_spikes;
   logic        net_enable;
   logic        net_delay_clk;
   logic [7:0]  net_output_spikes = '0;
   logic        net_data_ready = 1'b0;
   logic        busy;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [2:0]  res_class;
   logic [39:0] res_counts;
   logic        err_timeout;

   int tests = 0;
   int fails = 0;

   snn_inference_sequencer dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .num_steps         (num_steps),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_spikes         (in_spikes),
      .net_input_spikes  (net_input_spikes),
      .net_enable        (net_enable),
      .net_delay_clk     (net_delay_clk),
      .net_output_spikes (net_output_spikes),
      .net_data_ready    (net_data_ready),
      .busy              (busy),
      .res_valid         (res_valid),
      .res_ready         (res_ready),
      .res_class         (res_class),
      .res_counts        (res_counts),
      .err_timeout       (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ns;
      int          lat;
      logic [7:0]  sp;
      int          stall;
      logic [39:0] ecnt;
      logic [2:0]  ecls;
      logic        eerr;
      int          een;
      int          edclk;
      int          erdy;
   } vec_t;

   vec_t tbl[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: largest count, first index holding it.
   function automatic logic [2:0] ref_class(input int c[8]);
      int mx;
      mx = 0;
      for (int i = 0; i < 8; i++) if (c[i] > mx) mx = c[i];
      for (int i = 0; i < 8; i++) if (c[i] == mx) return 3'(i);
      return 3'd0;
   endfunction

   // Drives one inference with a behavioural network (latency lat cycles
   // after the enable pulse; lat=0 never answers, lat<0 random 1..8).
   // rst_at_en>0: assert reset in the first WAIT cycle after that enable.
   task automatic run_inf(input int ns, input int lat, input bit rnd, input logic [7:0] fsp,
                          input int stall, input int rst_at_en,
                          output int n_en, output int n_dclk, output int n_rdy, output int fr_err,
                          output bit done, output logic [39:0] m_cnt, output logic [2:0] m_cls);
      int         mc[8];
      int         cd;
      bit         armed;
      int         stall_left;
      int         cur_lat;
      logic [7:0] pend;
      logic [7:0] cur_sp;
      for (int i = 0; i < 8; i++) mc[i] = 0;
      cd = 0; armed = 0; stall_left = stall; cur_sp = '0; cur_lat = 0;
      pend = net_input_spikes;
      n_en = 0; n_dclk = 0; n_rdy = 0; fr_err = 0; done = 0;
      start = 1'b1;
      num_steps = 5'(ns);
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (res_valid) begin
            done = 1;
            break;
         end
         if (net_enable) begin
            n_en++;
            if (net_input_spikes !== pend) fr_err++;
            cur_lat = (lat < 0) ? int'($urandom_range(1, 8)) : lat;
            cd = cur_lat;
            armed = (cur_lat > 0);
            cur_sp = rnd ? 8'($urandom) : fsp;
         end else if (cd > 0) begin
            cd--;
         end
         if (net_delay_clk) n_dclk++;
         if (rst_at_en > 0 && n_en == rst_at_en && !net_enable) begin
            #2;
            reset = 1'b1;
            #1;
            break;
         end
         if (armed && cd == 0) begin
            net_data_ready = 1'b1;
            net_output_spikes = cur_sp;
            for (int i = 0; i < 8; i++) if (cur_sp[i] && mc[i] < 31) mc[i]++;
            armed = 0;
         end else begin
            net_data_ready = 1'b0;
            net_output_spikes = 8'($urandom);
         end
         if (in_ready) begin
            n_rdy++;
            if (stall_left > 0) begin
               in_valid = 1'b0;
               stall_left--;
            end else begin
               in_valid = 1'b1;
               in_spikes = 8'($urandom);
               pend = in_spikes;
               stall_left = stall;
            end
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_spikes = 8'($urandom);
         end
         tick();
      end
      in_valid = 1'b0;
      net_data_ready = 1'b0;
      for (int i = 0; i < 8; i++) m_cnt[i*5 +: 5] = 5'(mc[i]);
      m_cls = ref_class(mc);
   endtask

   task automatic consume();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      int          n_en, n_dclk, n_rdy, fr_err;
      bit          done;
      logic [39:0] m_cnt;
      logic [2:0]  m_cls;
      int          ns, st;

      tbl[0] = '{1,  3, 8'h04, 0,  40'h00_0000_0400,                    3'd2, 1'b0, 1,  1,  1};
      tbl[1] = '{31, 3, 8'h81, 0,  {5'd31, {6{5'd0}}, 5'd31},           3'd0, 1'b0, 31, 31, 31};
      tbl[2] = '{3,  3, 8'h10, 10, {{3{5'd0}}, 5'd3, {4{5'd0}}},        3'd4, 1'b0, 3,  3,  33};
      tbl[3] = '{4,  0, 8'h00, 0,  40'h0,                               3'd0, 1'b1, 1,  0,  1};
      tbl[4] = '{0,  3, 8'h00, 0,  40'h0,                               3'd0, 1'b0, 0,  0,  0};
      tbl[5] = '{2,  8, 8'hFF, 0,  {8{5'd2}},                           3'd0, 1'b0, 2,  2,  2};
      tbl[6] = '{5,  4, 8'h06, 1,  {{5{5'd0}}, 5'd5, 5'd5, 5'd0},       3'd1, 1'b0, 5,  5,  10};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy, in_ready, net_enable, net_delay_clk, res_valid, err_timeout,
                              res_class, res_counts, net_input_spikes}, 64'h0);
      reset = 1'b0;
      tick();
      check("idle_after_reset", {busy, in_ready, net_enable, res_valid}, 64'h0);

      // Table-driven inferences
      for (int r = 0; r < 7; r++) begin
         run_inf(tbl[r].ns, tbl[r].lat, 1'b0, tbl[r].sp, tbl[r].stall, 0,
                 n_en, n_dclk, n_rdy, fr_err, done, m_cnt, m_cls);
         check($sformatf("row%0d_done", r), done, 1);
         check($sformatf("row%0d_counts", r), res_counts, tbl[r].ecnt);
         check($sformatf("row%0d_class", r), res_class, tbl[r].ecls);
         check($sformatf("row%0d_err", r), err_timeout, tbl[r].eerr);
         check($sformatf("row%0d_enables", r), n_en, tbl[r].een);
         check($sformatf("row%0d_dclks", r), n_dclk, tbl[r].edclk);
         check($sformatf("row%0d_ready_cycles", r), n_rdy, tbl[r].erdy);
         check($sformatf("row%0d_frames", r), fr_err, 0);
         consume();
         check($sformatf("row%0d_idle", r), {res_valid, busy}, 0);
         if (tbl[r].eerr) check($sformatf("row%0d_err_sticky", r), err_timeout, 1);
      end

      // Result backpressure with start pulses during DONE
      run_inf(1, 3, 1'b0, 8'h04, 0, 0, n_en, n_dclk, n_rdy, fr_err, done, m_cnt, m_cls);
      check("bp_done", done, 1);
      for (int k = 0; k < 5; k++) begin
         start = 1'b1;
         num_steps = 5'd7;
         tick();
         check($sformatf("bp_hold%0d", k), {res_valid, busy, res_class, res_counts},
               {1'b1, 1'b1, 3'd2, 40'h00_0000_0400});
      end
      start = 1'b0;
      consume();
      check("bp_released", {res_valid, busy, in_ready}, 0);
      check("bp_class_kept", res_class, 2);

      // Reset in WAIT of step 2, then a fresh inference
      run_inf(4, 3, 1'b0, 8'h01, 0, 2, n_en, n_dclk, n_rdy, fr_err, done, m_cnt, m_cls);
      check("rst_not_done", done, 0);
      check("rst_outputs", {busy, in_ready, net_enable, net_delay_clk, res_valid, err_timeout,
                            res_class, res_counts, net_input_spikes}, 64'h0);
      reset = 1'b0;
      tick();
      run_inf(3, 3, 1'b0, 8'h22, 0, 0, n_en, n_dclk, n_rdy, fr_err, done, m_cnt, m_cls);
      check("post_rst_done", done, 1);
      check("post_rst_counts", res_counts, {{2{5'd0}}, 5'd3, {3{5'd0}}, 5'd3, 5'd0});
      check("post_rst_class", res_class, 1);
      check("post_rst_enables", n_en, 3);
      consume();

      // Randomized inferences against the reference model
      for (int k = 0; k < 10; k++) begin
         ns = $urandom_range(0, 12);
         st = $urandom_range(0, 2);
         run_inf(ns, -1, 1'b1, 8'h00, st, 0, n_en, n_dclk, n_rdy, fr_err, done, m_cnt, m_cls);
         check($sformatf("rnd%0d_done", k), done, 1);
         check($sformatf("rnd%0d_counts", k), res_counts, m_cnt);
         check($sformatf("rnd%0d_class", k), res_class, m_cls);
         check($sformatf("rnd%0d_err", k), err_timeout, 0);
         check($sformatf("rnd%0d_enables", k), n_en, ns);
         check($sformatf("rnd%0d_dclks", k), n_dclk, ns);
         check($sformatf("rnd%0d_frames", k), fr_err, 0);
         consume();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/snn_inference_sequencer.md
Name: snn_inference_sequencer

Overview:
- Controller for the three-layer delayed spiking network. It runs one inference of runtime-selectable length (num_steps timesteps).
- Each timestep: accept an 8-bit input spike frame over valid/ready, pulse the network enable, wait for the network's output_data_ready, accumulate per-neuron output spike counts, then pulse the delay clock.
- At the end it presents the counts and the argmax class over a valid/ready result handshake.
- Sits between the stimulus/host interface and the network instance.

Parameters:
- N_IN, 8, input spike frame width (must match network input).
- N_OUT, 8, output neurons counted (must match network output).
- CNT_W, 5, spike counter width per output neuron; counters saturate at 2^CNT_W-1.
- STEP_W, 5, width of num_steps.
- TIMEOUT, 8, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  begin inference; sampled only in IDLE
- num_steps  in  STEP_W  timestep count; latched on accepted start
- in_valid  in  1  input frame valid
- in_ready  out  1  sequencer accepts frame
- in_spikes  in  N_IN  input spike frame
- net_input_spikes  out  N_IN  registered frame driven to network input_spikes
- net_enable  out  1  network enable, one-cycle pulse per timestep
- net_delay_clk  out  1  network delay_clk, one-cycle pulse per timestep
- net_output_spikes  in  N_OUT  network output_spikes (final layer)
- net_data_ready  in  1  network output_data_ready
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_class  out  3  index of the maximum count
- res_counts  out  N_OUT*CNT_W  per-neuron counts; neuron i at bits [i*CNT_W +: CNT_W]
- err_timeout  out  1  sticky; set on WAIT timeout, cleared on next accepted start

Behaviour:
Reset: state IDLE. All outputs 0. Counters, step, timer, latched num_steps and net_input_spikes are 0.

States and transitions:
- IDLE: in_ready=0, busy=0.
  - start=1 and num_steps!=0: latch num_steps, clear counters, step and err_timeout, go FETCH.
  - start=1 and num_steps==0: clear counters, go DONE with res_class=0.
  - start while not IDLE is ignored.
- FETCH: in_ready=1.
  - On in_valid&in_ready, register in_spikes into net_input_spikes, go FIRE.
  - net_input_spikes holds its value until the next accepted frame.
- FIRE: net_enable=1 for exactly this one cycle; clear timer; go WAIT.
- WAIT: timer increments each cycle.
  - net_data_ready=1: for each i, if net_output_spikes[i] then count[i]+=1, saturating. Go DCLK.
  - Otherwise, timer==TIMEOUT-1: set err_timeout, go DONE with the counts as they stand.
  - net_data_ready is ignored outside WAIT.
  - Nominal network latency is 3 cycles after the net_enable pulse.
- DCLK: net_delay_clk=1 for this one cycle.
  - If step==num_steps_latched-1, go DONE; else step+=1, go FETCH.
- DONE: res_valid=1.
  - res_class and res_counts are registered on entry and held stable while res_valid=1.
  - On res_valid&res_ready, go IDLE (res_valid drops next cycle).
  - res_counts and res_class keep their values until the next accepted start clears them.

Rules:
- Argmax: the largest count wins; ties go to the lowest index; all-zero counts give class 0.
- Per-timestep minimum latency is 6 cycles (FETCH 1, FIRE 1, WAIT 3, DCLK 1) when in_valid is already high.
- Asynchronous reset mid-inference returns to IDLE immediately and drops net_enable/net_delay_clk.
- Outputs are registered state decodes; no combinational path from inputs to net_enable or net_delay_clk.

Decomposition:
- Package snn_ctrl_pkg: state encoding (IDLE, FETCH, FIRE, WAIT, DCLK, DONE), default widths, TIMEOUT constant.
- Sub-module spike_count_argmax: holds the N_OUT saturating counters (clear, accumulate enable, spike vector) and the registered tie-lowest-index argmax.
- The FSM, step/timer counters and handshakes live in the top.

Test Plan:
- Single-step inference: num_steps=1, frame 8'hA5, network model returns output_spikes=8'h04 three cycles after enable → net_enable pulsed once, net_delay_clk pulsed once, res_counts neuron2=1 and others 0, res_class=2, err_timeout=0.
- Multi-step accumulation with saturation: num_steps=31, model always returns 8'h81 → counts[0]=counts[7]=31, others 0, res_class=0 (tie to lowest); 31 enable pulses and 31 delay_clk pulses.
- Input backpressure: num_steps=3, in_valid withheld for 10 cycles before each frame → in_ready stays high, net_enable stays low until each handshake, then exactly 3 enables total.
- Timeout: model never asserts net_data_ready → after 8 WAIT cycles err_timeout=1, res_valid=1 with counts 0; the next start clears err_timeout.
- Result backpressure and zero steps: res_ready held low 5 cycles → res_valid and res_class stable; start during DONE ignored. Separately, num_steps=0 → DONE next cycle, no net_enable, res_class=0.
- Reset mid-operation: assert reset in WAIT of step 2 → same-cycle return to IDLE, all outputs 0; a subsequent fresh start runs a full inference correctly.
